// File: rtl/game_pkg.sv
// Shared game definitions: game FSM state codes, visible-window bounds and
// state-class helpers used by the level block, the top FSM and collision_detect.
package game_pkg;

  // Game FSM state codes (4 bits)
  localparam logic [3:0] ST_TITLE   = 4'd0;
  localparam logic [3:0] ST_CHARSEL = 4'd1;
  localparam logic [3:0] ST_IDLE    = 4'd2;
  localparam logic [3:0] ST_RUN1    = 4'd3;
  localparam logic [3:0] ST_RUN2    = 4'd4;
  localparam logic [3:0] ST_JUMP1   = 4'd5;
  localparam logic [3:0] ST_JUMP2   = 4'd6;
  localparam logic [3:0] ST_DUCK1   = 4'd7;
  localparam logic [3:0] ST_DUCK2   = 4'd8;
  localparam logic [3:0] ST_FAIL1   = 4'd9;
  localparam logic [3:0] ST_FAIL2   = 4'd10;

  // Visible window (inclusive) and the line whose first pixel closes a frame
  localparam logic [9:0] VIS_H_MIN   = 10'd143;
  localparam logic [9:0] VIS_H_MAX   = 10'd784;
  localparam logic [9:0] VIS_V_MIN   = 10'd34;
  localparam logic [9:0] VIS_V_MAX   = 10'd516;
  localparam logic [9:0] FRAME_END_V = 10'd517;

  // Collision detector FSM states
  typedef enum logic [1:0] {
    CD_DISARMED = 2'd0,
    CD_GRACE    = 2'd1,
    CD_ARMED    = 2'd2,
    CD_HIT      = 2'd3
  } cd_state_t;

  function automatic logic is_running(input logic [3:0] st);
    case (st)
      ST_RUN1, ST_RUN2, ST_JUMP1, ST_JUMP2, ST_DUCK1, ST_DUCK2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_hold(input logic [3:0] st);
    case (st)
      ST_FAIL1, ST_FAIL2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Codes that mean "no game in progress": force the detector back to DISARMED
  function automatic logic is_disarm(input logic [3:0] st);
    case (st)
      ST_TITLE, ST_CHARSEL, ST_IDLE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/overlap_counter.sv
// Per-frame overlap pixel counter: window test, saturating count, in_frame
// flag and single frame-end strobe per visible frame.
module overlap_counter
  import game_pkg::*;
#(
  parameter int CNTW  = 12,
  parameter int CIDXW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic [CIDXW:0]    obstacle_pix,
  input  logic [CIDXW:0]    player_pix,
  output logic              frame_end,
  output logic [CNTW-1:0]   count
);

  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_ZERO = CNTW'(0);
  localparam logic [CIDXW:0]   PIX_NONE = (CIDXW + 1)'(0);

  logic            in_frame_r;
  logic [CNTW-1:0] count_r;
  logic            in_window_s;
  logic            overlap_s;
  logic            frame_end_s;

  assign in_window_s = (hc >= VIS_H_MIN) && (hc <= VIS_H_MAX) &&
                       (vc >= VIS_V_MIN) && (vc <= VIS_V_MAX);
  assign overlap_s   = pix_en && in_window_s &&
                       (obstacle_pix != PIX_NONE) && (player_pix != PIX_NONE);
  // in_frame guarantees only the first pix_en cycle on the end line fires
  assign frame_end_s = pix_en && (vc == FRAME_END_V) && in_frame_r;

  assign frame_end = frame_end_s;
  assign count     = count_r;

  // Arm at the top visible line, disarm on the frame-end strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_r <= 1'b0;
    end else if (frame_end_s) begin
      in_frame_r <= 1'b0;
    end else if (pix_en && (vc == VIS_V_MIN)) begin
      in_frame_r <= 1'b1;
    end else begin
      in_frame_r <= in_frame_r;
    end
  end

  // Saturating overlap count, cleared in the same cycle it is evaluated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (frame_end_s) begin
      count_r <= CNT_ZERO;
    end else if (overlap_s && !(&count_r)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/collision_detect.sv
// Player/obstacle collision detector: grace period after entering a running
// state, then a frame-granular threshold test producing a hit pulse and a
// held collided flag.
module collision_detect
  import game_pkg::*;
#(
  parameter int HIT_THRESH   = 8,
  parameter int GRACE_FRAMES = 30,
  parameter int CNTW         = 12,
  parameter int CIDXW        = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              pix_en,
  input  logic [3:0]        state,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic [CIDXW:0]    obstacle_pix,
  input  logic [CIDXW:0]    player_pix,
  output logic              hit,
  output logic              collided,
  output logic [CNTW-1:0]   last_count,
  output logic              armed
);

  localparam int              GW         = $clog2(GRACE_FRAMES + 1);
  localparam logic [GW-1:0]   GRACE_ZERO = GW'(0);
  localparam logic [GW-1:0]   GRACE_ONE  = GW'(1);
  localparam logic [GW-1:0]   GRACE_LAST = GW'(GRACE_FRAMES);
  localparam logic [CNTW-1:0] THRESH     = CNTW'(HIT_THRESH);

  cd_state_t       fsm_r, fsm_next_s;
  logic [GW-1:0]   grace_r, grace_next_s;
  logic            hit_r, hit_next_s;
  logic            collided_r, armed_r;
  logic [CNTW-1:0] last_count_r;
  logic            frame_end_s;
  logic [CNTW-1:0] frame_count_s;

  overlap_counter #(.CNTW(CNTW), .CIDXW(CIDXW)) u_overlap (
    .clk          (CLK),
    .rst_n        (RESET_N),
    .pix_en       (pix_en),
    .hc           (hc),
    .vc           (vc),
    .obstacle_pix (obstacle_pix),
    .player_pix   (player_pix),
    .frame_end    (frame_end_s),
    .count        (frame_count_s)
  );

  // Next-state logic; a disarm code beats any same-cycle frame evaluation
  always_comb begin
    fsm_next_s   = fsm_r;
    grace_next_s = grace_r;
    hit_next_s   = 1'b0;
    if (is_disarm(state)) begin
      fsm_next_s   = CD_DISARMED;
      grace_next_s = GRACE_ZERO;
    end else begin
      case (fsm_r)
        CD_DISARMED: begin
          if (is_running(state)) begin
            fsm_next_s   = CD_GRACE;
            grace_next_s = GRACE_ZERO;
          end else begin
            fsm_next_s = CD_DISARMED;
          end
        end
        CD_GRACE: begin
          if (frame_end_s && !is_hold(state)) begin
            if (grace_r + GRACE_ONE == GRACE_LAST) begin
              fsm_next_s   = CD_ARMED;
              grace_next_s = GRACE_LAST;
            end else begin
              grace_next_s = grace_r + GRACE_ONE;
            end
          end else begin
            grace_next_s = grace_r;
          end
        end
        CD_ARMED: begin
          if (frame_end_s && !is_hold(state) && (frame_count_s >= THRESH)) begin
            fsm_next_s = CD_HIT;
            hit_next_s = 1'b1;
          end else begin
            fsm_next_s = CD_ARMED;
          end
        end
        CD_HIT: begin
          fsm_next_s = CD_HIT;
        end
        default: begin
          fsm_next_s   = CD_DISARMED;
          grace_next_s = GRACE_ZERO;
        end
      endcase
    end
  end

  // FSM state and grace frame counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_r   <= CD_DISARMED;
      grace_r <= GRACE_ZERO;
    end else begin
      fsm_r   <= fsm_next_s;
      grace_r <= grace_next_s;
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_r        <= 1'b0;
      collided_r   <= 1'b0;
      armed_r      <= 1'b0;
      last_count_r <= CNTW'(0);
    end else begin
      hit_r      <= hit_next_s;
      collided_r <= (fsm_next_s == CD_HIT);
      armed_r    <= (fsm_next_s == CD_ARMED);
      if (frame_end_s) begin
        last_count_r <= frame_count_s;
      end else begin
        last_count_r <= last_count_r;
      end
    end
  end

  assign hit        = hit_r;
  assign collided   = collided_r;
  assign armed      = armed_r;
  assign last_count = last_count_r;

endmodule

// File: doc/collision_detect.md
# collision_detect

Per-pixel overlap detector between the player sprite stream and the obstacle stream produced by the level block. Counts overlapping opaque pixels across each visible frame and, after a grace period, raises a single-cycle `hit` pulse plus a held `collided` flag. The top-level game FSM consumes these to move from the RUN/JUMP/DUCK states into FAIL1.

## Interface
- `HIT_THRESH`, 8: minimum overlapping pixels in one frame that counts as a hit.
- `GRACE_FRAMES`, 30: complete frames ignored after entering a running state.
- `CNTW`, 12: overlap counter width; the counter saturates at 2^CNTW-1.
- `CIDXW`, 3: pixel index MSB; pixel buses are CIDXW+1 bits wide.

- `CLK`  in  1  system clock; the only clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel strobe, one CLK per VGA pixel (25 MHz rate).
- `state`  in  4  game FSM state code.
- `hc`  in  10  horizontal counter.
- `vc`  in  10  vertical counter.
- `obstacle_pix`  in  CIDXW+1  obstacle pixel index; 0 = transparent.
- `player_pix`  in  CIDXW+1  player sprite pixel index; 0 = transparent.
- `hit`  out  1  one-CLK pulse when a hit is declared.
- `collided`  out  1  held high from the hit until the game is reset.
- `last_count`  out  CNTW  overlap count of the most recently completed frame.
- `armed`  out  1  high while in ARMED.

## Operation
- Visible window: hc 143..784 and vc 34..516, both inclusive. Pixel inputs are aligned with hc/vc by the caller; this block adds no alignment delay.
- A pixel is an overlap when all of these hold: `pix_en`, the pixel is in the window, `obstacle_pix != 0`, and `player_pix != 0`.
- Overlap counter:
  - Increments by 1 per overlap pixel and saturates at all-ones.
  - Cleared on the frame-end cycle, in the same cycle as the evaluation.
- Frame end: the first `pix_en` cycle with vc == 517.
  - A one-bit `in_frame` flag, set at vc == 34, ensures each frame ends exactly once.
  - On frame end, the pre-clear counter value is copied into `last_count`.
- Running states: RUN1, RUN2, JUMP1, JUMP2, DUCK1, DUCK2. Hold states: FAIL1, FAIL2.
- FSM states and transitions:
  - DISARMED: enter GRACE when `state` is a running state.
  - GRACE: a frame counter starts at 0 and increments at each frame end. Enter ARMED when it reaches GRACE_FRAMES.
  - ARMED: at frame end, if the count is ≥ HIT_THRESH, pulse `hit` and enter HIT.
  - HIT: `collided` = 1. Stay in HIT through the hold states and any running state.
  - From any state, `state` == IDLE or any title/charsel code goes to DISARMED. This clears `collided` and the grace counter.
  - GRACE or ARMED with `state` in a hold state: remain, with evaluation suppressed.
- Simultaneous events:
  - If a state-code exit and frame end fall in the same cycle, the exit wins: no hit, and the block goes to DISARMED.
  - A counter at saturation still compares correctly against HIT_THRESH.
- Reset (`RESET_N` low, async, at any time): FSM = DISARMED, all counters = 0, `hit` = 0, `collided` = 0, `last_count` = 0, `armed` = 0, `in_frame` = 0.

## Timing
- `hit` is registered and goes high exactly 1 CLK after the frame-end evaluation cycle. It is high for one CLK only.
- `collided` rises in the same cycle as `hit`.
- `last_count` updates 1 CLK after frame end.
- Decisions are frame-granular: worst-case detection latency is one full frame after the first overlap pixel.
- The counter ignores cycles where `pix_en` is low, regardless of hc/vc.

## Structure
- Shared package `game_pkg`:
  - 4-bit state codes: TITLE..FAIL2.
  - Visible-window bounds: 143/784/34/516, and frame-end line 517.
  - Helper functions `is_running(state)` and `is_hold(state)`.
  - This package is also consumed by the level block and the top FSM.
- Sub-module `overlap_counter`:
  - Contains the window test, the saturating CNTW counter, the `in_frame` flag and frame-end generation.
  - Outputs `frame_end` and `count`.
- The parent holds the FSM, the grace counter and the output registers.

## Test plan
- Reset mid-frame with overlaps present: all outputs are 0 on the next CLK, FSM is DISARMED, and the first frame end after release produces no `hit`.
- State goes to RUN1, then 10 overlap pixels per frame starting immediately: no `hit` for 30 frames, `armed` rises at the 30th frame end, and `hit` pulses once at the 31st frame end with `last_count` = 10.
- ARMED with 7 overlaps per frame for 100 frames: `hit` never fires and `last_count` = 7 each frame. Then 8 overlaps in one frame: `hit` fires.
- ARMED with overlaps placed only at hc = 142, hc = 785, vc = 33, and with `pix_en` = 0: `last_count` = 0 and no `hit`.
- `collided` held through FAIL1/FAIL2 and back to RUN1 with no second `hit`. Then state = IDLE: `collided` drops and the next RUN1 restarts the grace period.
- CNTW = 4, HIT_THRESH = 15, 40 overlaps in one frame: the counter saturates at 15, `last_count` = 15, and `hit` fires. Separately, state drops to IDLE on the frame-end cycle: no `hit`.
